// File: rtl/cln_pipe_keyed.sv
// cln_pipe_keyed: pipelined, keyed switch-box locking network.
// N-bit words pass through STAGES registered switch-box stages joined by a
// perfect-shuffle interconnect, with valid/ready flow control and a global stall.
// The key is streamed into a shadow register and copied to the active key only
// once the pipeline has drained, so no word ever sees a mix of two keys.
// Optional build macro CLN_KEY_ERR_EN adds a sticky key_err output flagging
// protocol misuse of the key interface.
//
// Key FSM states:
//   state     | meaning
//   K_EMPTY   | no partial load in progress; next beat starts at beat 0
//   K_LOADING | some beats written to shadow, more expected
//   K_FULL    | shadow complete, waiting for key_commit
//   K_DRAIN   | commit requested, input blocked until pipeline is empty
module cln_pipe_keyed #(
  parameter int N      = 16,
  parameter int STAGES = 5,
  parameter int KEY_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_data,
  output logic             key_ready,
  input  logic             key_commit,
  output logic             key_active,
`ifdef CLN_KEY_ERR_EN
  output logic             key_err,
`endif
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  input  logic             out_ready
);

  localparam int NB        = N * STAGES / 2;
  localparam int KEY_TOTAL = 3 * NB;
  localparam int BEATS     = KEY_TOTAL / KEY_W;
  localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {K_EMPTY, K_LOADING, K_FULL, K_DRAIN} kstate_t;

  kstate_t                state, state_nx;
  logic [CW-1:0]          beat_cnt;
  logic [KEY_TOTAL-1:0]   key_shadow;
  logic [KEY_TOTAL-1:0]   key_act;
  logic                   load_act;
  logic                   beat_acc;
  logic                   last_beat;
  logic                   pipe_empty;
  logic                   advance;
  logic                   in_acc;
  logic [N-1:0]           stage_d  [STAGES];
  logic [N-1:0]           stage_nx [STAGES];
  logic [STAGES-1:0]      stage_v;

  // Perfect shuffle: lower half goes to even slots, upper half to odd slots.
  function automatic logic [N-1:0] shuffle(input logic [N-1:0] x);
    logic [N-1:0] y;
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (i < N / 2) y[2*i] = x[i];
      else           y[2*i+1-N] = x[i];
    end
    return y;
  endfunction

  // One column of N/2 switch boxes; K0 swaps the pair, K1/K2 invert O0/O1.
  function automatic logic [N-1:0] box_stage(input logic [N-1:0] x, input int s,
                                             input logic [KEY_TOTAL-1:0] k);
    logic [N-1:0] y;
    int idx;
    y = '0;
    for (int b = 0; b < N / 2; b++) begin
      idx = s * (N / 2) + b;
      y[2*b]   = (k[idx] ? x[2*b+1] : x[2*b])   ^ k[NB+idx];
      y[2*b+1] = (k[idx] ? x[2*b]   : x[2*b+1]) ^ k[2*NB+idx];
    end
    return y;
  endfunction

  assign beat_acc   = key_valid & key_ready;
  assign last_beat  = beat_acc & (beat_cnt == CW'(BEATS - 1));
  assign pipe_empty = ~|stage_v;
  assign out_valid  = stage_v[STAGES-1];
  assign out_data   = stage_d[STAGES-1];
  assign advance    = out_ready | ~out_valid;
  assign in_ready   = key_active & (state != K_DRAIN) & advance;
  assign in_acc     = in_valid & in_ready;

  // Key FSM next state, beat acceptance and active-key load strobe.
  always_comb begin
    state_nx  = state;
    key_ready = 1'b0;
    load_act  = 1'b0;
    case (state)
      K_EMPTY: begin
        key_ready = 1'b1;
        if (key_valid) state_nx = last_beat ? K_FULL : K_LOADING;
      end
      K_LOADING: begin
        key_ready = 1'b1;
        if (last_beat) state_nx = K_FULL;
      end
      K_FULL: begin
        if (key_commit) state_nx = K_DRAIN;
      end
      K_DRAIN: begin
        if (pipe_empty) begin
          state_nx = K_EMPTY;
          load_act = 1'b1;
        end
      end
      default: state_nx = K_EMPTY;
    endcase
  end

  // Key state, beat counter, shadow fill and atomic active-key update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= K_EMPTY;
      beat_cnt   <= '0;
      key_shadow <= '0;
      key_act    <= '0;
      key_active <= 1'b0;
    end else begin
      state <= state_nx;
      if (beat_acc) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      for (int j = 0; j < BEATS; j++) begin
        if (beat_acc && beat_cnt == CW'(j)) key_shadow[j*KEY_W +: KEY_W] <= key_data;
      end
      if (load_act) begin
        key_act    <= key_shadow;
        key_active <= 1'b1;
      end
    end
  end

`ifdef CLN_KEY_ERR_EN
  // Sticky misuse flag; a fresh load (beat 0) clears it unless misuse coincides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_err <= 1'b0;
    end else if ((key_commit && (state == K_EMPTY || state == K_LOADING)) ||
                 (key_valid  && (state == K_FULL  || state == K_DRAIN))) begin
      key_err <= 1'b1;
    end else if (beat_acc && state == K_EMPTY) begin
      key_err <= 1'b0;
    end
  end
`endif

  // Per-stage combinational result: shuffle of previous stage, then box column.
  always_comb begin
    for (int s = 0; s < STAGES; s++) stage_nx[s] = '0;
    stage_nx[0] = box_stage(in_data, 0, key_act);
    for (int s = 1; s < STAGES; s++) stage_nx[s] = box_stage(shuffle(stage_d[s-1]), s, key_act);
  end

  // Pipeline registers: all stages shift together on advance, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v <= '0;
      for (int s = 0; s < STAGES; s++) stage_d[s] <= '0;
    end else if (advance) begin
      stage_v[0] <= in_acc;
      if (in_acc) stage_d[0] <= stage_nx[0];
      for (int s = 1; s < STAGES; s++) begin
        stage_v[s] <= stage_v[s-1];
        if (stage_v[s-1]) stage_d[s] <= stage_nx[s];
      end
    end
  end

endmodule

// File: doc/cln_pipe_keyed.md
Name: cln_pipe_keyed

Overview:
- Pipelined, sequential successor to the combinational switch-box locking network.
- N-bit datapath through STAGES switch-box stages, with a shuffle interconnect between consecutive stages; one register per stage.
- Valid/ready streaming with backpressure.
- Key is loaded serially into a shadow register and committed atomically to the active key only when the pipeline is drained.

Parameters:
- N, 16: datapath width; power of 2, >= 4.
- STAGES, 5: switch-box stages (log2(N)+1 default).
- KEY_W, 8: key beat width; must divide KEY_TOTAL = 3*N*STAGES/2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key beat valid
- key_data  in  KEY_W  key beat
- key_ready  out  1  beat accepted when key_valid & key_ready
- key_commit  in  1  request shadow->active transfer (single-cycle pulse)
- key_active  out  1  active key valid
- in_valid  in  1  input valid
- in_data  in  N  input word
- in_ready  out  1  input accepted
- out_valid  out  1  output valid
- out_data  out  N  locked output word
- out_ready  in  1  downstream ready

Behaviour:
- Reset values: key_ready=1, key_active=0, in_ready=0, out_valid=0, out_data=0. Both key registers, all stage registers and all stage valids clear to 0. Reset mid-operation discards all data and both keys.
- Switch box: I0=x[2b], I1=x[2b+1]. K0=1 swaps the pair. K1=1 inverts O0; K2=1 inverts O1.
- Shuffle between stage s and s+1, i<N/2: y[2i]=x[i]; else y[2i+1-N]=x[i]. No shuffle after the last stage.
- Key layout: NB=N*STAGES/2. Flat key bits [NB-1:0] are K0, [2NB-1:NB] are K1, [3NB-1:2NB] are K2. Stage s, box b uses index s*N/2+b within each field.
- Key load: beats fill the shadow register LSB-first, so beat j writes bits [j*KEY_W +: KEY_W]. A beat counter tracks progress; once BEATS=KEY_TOTAL/KEY_W beats are in, shadow is full and key_ready=0 until commit. The first beat after a commit restarts at beat 0.
- Key FSM:
  - EMPTY -> LOADING: first beat accepted.
  - LOADING -> FULL: last beat accepted.
  - FULL -> DRAIN: on key_commit.
  - DRAIN -> EMPTY: when all stage valids = 0; copy shadow to active and set key_active=1.
  - key_commit in EMPTY or LOADING is ignored.
- Input gating: in_ready = key_active & (state != DRAIN) & advance.
- Pipeline: advance = out_ready | ~out_valid. All stages shift together when advance=1 and hold otherwise (global stall). Latency is STAGES cycles from acceptance to out_valid at 1 per cycle with no stalls.
- out_data holds its value while out_valid & ~out_ready.
- Simultaneous key_commit and the last beat: the commit is ignored, because the FSM is not yet FULL.

Optional Feature:
- Macro: CLN_KEY_ERR_EN.
- With the macro: adds output key_err (1 bit, reset 0), a sticky flag. It is set by key_commit in EMPTY/LOADING, or by key_valid while FULL/DRAIN. It clears on reset or on the first beat of a new load.
- Without the macro: no port; those events are silently ignored.

Test Plan:
- N=4, STAGES=3, KEY_W=6 (3 beats). Load beats 6'h00,6'h00,6'h00, pulse commit -> key_active=1 after drain. Send in_data=4'b1010 -> out_data=4'b1010 exactly 3 cycles after acceptance.
- Same config, beats 6'h00,6'h3F,6'h3F (all-invert) -> in_data=4'b1010 gives out_data=4'b0101.
- Same config, beats 6'h01,6'h00,6'h00 (stage 0 box 0 swap) -> in_data=4'b0001 gives out_data=4'b0010.
- Stream 3 words with out_ready=0 -> in_ready drops once the pipeline is full and out_data is stable. Raise out_ready -> words emerge in order, none lost or duplicated.
- Commit a new key while 2 words are in flight -> in_ready=0 until they exit under the old key; the next word uses the new key.
- Assert rst_n=0 mid-stream -> out_valid=0 and key_active=0 at once (asynchronously). With CLN_KEY_ERR_EN, a commit after 1 beat sets key_err=1.
